// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus definitions: request direction codes, well-known
// register addresses and the OAM DMA sequencer state encoding.
package nes_bus_pkg;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [15:0] OAM_DMA_REG = 16'h4014;
  localparam logic [15:0] PPU_OAMDATA = 16'h2004;

  typedef enum logic [2:0] {
    S_Idle,
    S_Rd,
    S_RdGap,
    S_Wr,
    S_WrGap
  } oam_dma_state_e;

endpackage

// File: rtl/oam_dma_if.sv
// Shared CPU-bus request/Finish handshake. The initiator (master) drives the
// request; whichever responder decodes Addr returns Finish and RData.
interface oam_dma_if;
  logic [15:0] Addr;
  logic [7:0]  WData;
  logic [7:0]  RData;
  logic        Cmd;
  logic        RW;
  logic        Finish;

  modport master (output Addr, WData, Cmd, RW, input RData, Finish);
  modport slave  (input Addr, WData, Cmd, RW, output RData, Finish);
endinterface

// File: rtl/bus_xact.sv
// One bus transaction at a time: holds the registered request stable until
// Finish, captures read data, and aborts after TIMEOUT cycles without Finish.
module bus_xact
  import nes_bus_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        rw,
  input  logic        park,
  output logic [7:0]  rdata,
  output logic        ok,
  output logic        tmo,
  oam_dma_if.master   bus
);

  logic        cmd_q,  cmd_d;
  logic        rw_q,   rw_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  cnt_q,  cnt_d;

  // Bus request registers and wait counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q  <= 1'b0;
      rw_q   <= RW_READ;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      cmd_q  <= cmd_d;
      rw_q   <= rw_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  // Handshake: start loads a request, Finish or timeout retires it.
  // Timeout fires on the cycle the counter would reach TIMEOUT, so Cmd is
  // high for exactly TIMEOUT cycles on a dead responder.
  always_comb begin
    cmd_d  = cmd_q;
    rw_d   = rw_q;
    addr_d = addr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    ok     = cmd_q && bus.Finish;
    tmo    = cmd_q && !bus.Finish && (cnt_q == TIMEOUT - 8'd1);
    if (start) begin
      cmd_d  = 1'b1;
      addr_d = addr;
      rw_d   = rw;
      cnt_d  = '0;
      if (rw == RW_WRITE) data_d = wdata;
    end else if (ok) begin
      cmd_d = 1'b0;
      if (rw_q == RW_READ) data_d = bus.RData;
    end else if (tmo) begin
      cmd_d = 1'b0;
    end else if (cmd_q) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (park) rw_d = RW_READ;
  end

  assign rdata     = data_q;
  assign bus.Cmd   = cmd_q;
  assign bus.RW    = rw_q;
  assign bus.Addr  = addr_q;
  assign bus.WData = data_q;

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine: on a $4014 trigger copies 256 bytes from {page,00..FF}
// to the PPU OAM data port, halting the CPU via busy for the duration.
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] OAM_PORT = PPU_OAMDATA,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trig,
  input  logic [7:0] trig_page,
  output logic       busy,
  output logic       done,
  output logic       err,
  oam_dma_if.master  bus
);

  oam_dma_state_e state_q, state_d;
  logic [7:0]     page_q, page_d;
  logic [7:0]     idx_q,  idx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q,  err_d;

  logic        x_start, x_rw, x_park, x_ok, x_tmo;
  logic [15:0] x_addr;
  logic [7:0]  x_wdata, x_rdata;

  bus_xact #(.TIMEOUT(TIMEOUT)) u_xact (
    .clk   (clk),
    .rst_n (rst_n),
    .start (x_start),
    .addr  (x_addr),
    .wdata (x_wdata),
    .rw    (x_rw),
    .park  (x_park),
    .rdata (x_rdata),
    .ok    (x_ok),
    .tmo   (x_tmo),
    .bus   (bus)
  );

  // Sequencer state and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_Idle;
      page_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Read/write alternation across 256 bytes; gap states keep Cmd low one cycle.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    x_start = 1'b0;
    x_addr  = '0;
    x_wdata = x_rdata;
    x_rw    = RW_READ;
    x_park  = 1'b0;
    unique case (state_q)
      S_Idle: begin
        if (trig) begin
          page_d  = trig_page;
          idx_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          x_start = 1'b1;
          x_addr  = {trig_page, 8'h00};
          state_d = S_Rd;
        end
      end
      S_Rd: begin
        if (x_ok) begin
          state_d = S_RdGap;
        end else if (x_tmo) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_Idle;
        end
      end
      S_RdGap: begin
        x_start = 1'b1;
        x_addr  = OAM_PORT;
        x_rw    = RW_WRITE;
        state_d = S_Wr;
      end
      S_Wr: begin
        if (x_ok) begin
          state_d = S_WrGap;
        end else if (x_tmo) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_Idle;
        end
      end
      S_WrGap: begin
        if (idx_q == 8'hFF) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          x_park  = 1'b1;
          state_d = S_Idle;
        end else begin
          idx_d   = idx_q + 8'd1;
          x_start = 1'b1;
          x_addr  = {page_q, idx_q + 8'd1};
          state_d = S_Rd;
        end
      end
      default: state_d = S_Idle;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboarded bench for oam_dma: a RAM/OAM responder model answers the bus,
// expected reads/writes are queued at trigger time and retired by a monitor.
module tb_oam_dma;
  import nes_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig;
  logic [7:0]  trig_page;
  logic        busy, done, err;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr;

  logic        stall_en, hang_en, spur;
  logic [15:0] hang_addr;

  logic [15:0] exp_rd[$];
  logic [7:0]  exp_wr[$];

  int n_checks = 0;
  int n_fail   = 0;

  oam_dma_if bus ();

  assign trig      = cpu_wr && (cpu_addr == OAM_DMA_REG);
  assign trig_page = cpu_wdata;

  oam_dma #(.OAM_PORT(16'h2004), .TIMEOUT(8'd255)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig      (trig),
    .trig_page (trig_page),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Responder: Finish one cycle after Cmd is seen (plus optional stall);
  // RAM contents are mem[a] = a[7:0] ^ 8'h5A.
  initial begin
    int age;
    int stall;
    age = 0;
    bus.Finish = 1'b0;
    bus.RData  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.Finish = 1'b0;
      if (spur) begin
        bus.Finish = 1'b1;
      end else if (bus.Cmd) begin
        age++;
        stall = (stall_en && !bus.RW && bus.Addr[3:0] == 4'h0) ? 3 : 0;
        if (!(hang_en && !bus.RW && bus.Addr == hang_addr) && age >= 2 + stall) begin
          bus.Finish = 1'b1;
          if (!bus.RW) bus.RData = bus.Addr[7:0] ^ 8'h5A;
          age = 0;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Monitor: retires completed transactions against the queues and checks
  // request stability during stalls and the one-cycle Cmd gap.
  initial begin
    logic        prv_cmd, prv_fin, prv_rw;
    logic [15:0] prv_addr;
    logic [15:0] ea;
    logic [7:0]  ed;
    prv_cmd = 1'b0; prv_fin = 1'b0; prv_rw = 1'b0; prv_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prv_cmd = 1'b0;
        prv_fin = 1'b0;
      end else begin
        if (prv_cmd && prv_fin) chk("cmd_gap", bus.Cmd, 1'b0);
        if (prv_cmd && !prv_fin && bus.Cmd) begin
          chk("stall_addr", bus.Addr, prv_addr);
          chk("stall_rw", bus.RW, prv_rw);
        end
        if (bus.Cmd && bus.Finish) begin
          if (!bus.RW) begin
            if (exp_rd.size() == 0) chk("unexpected_read", bus.Addr, 16'hDEAD);
            else begin
              ea = exp_rd.pop_front();
              chk("rd_addr", bus.Addr, ea);
            end
          end else begin
            chk("wr_addr", bus.Addr, 16'h2004);
            if (exp_wr.size() == 0) chk("unexpected_write", bus.WData, 9'h100);
            else begin
              ed = exp_wr.pop_front();
              chk("wr_data", bus.WData, ed);
            end
          end
        end
        prv_cmd  = bus.Cmd;
        prv_fin  = bus.Finish;
        prv_rw   = bus.RW;
        prv_addr = bus.Addr;
      end
    end
  end

  task automatic push_exp(input logic [7:0] page, input int nrd, input int nwr);
    for (int i = 0; i < nrd; i++) exp_rd.push_back({page, 8'(i)});
    for (int i = 0; i < nwr; i++) exp_wr.push_back(8'(i) ^ 8'h5A);
  endtask

  // Issues the $4014 write; returns at the negedge of the first busy cycle.
  task automatic start(input logic [7:0] page);
    @(negedge clk);
    cpu_addr  = OAM_DMA_REG;
    cpu_wdata = page;
    cpu_wr    = 1'b1;
    @(negedge clk);
    cpu_wr   = 1'b0;
    cpu_addr = '0;
    chk("busy_after_trig", busy, 1'b1);
    chk("cmd_after_trig", bus.Cmd, 1'b1);
    chk("err_cleared", err, 1'b0);
  endtask

  task automatic wait_done(input int exp_cyc, input int retrig_at);
    int n;
    bit seen;
    n = 1;
    seen = 0;
    while (n < 5000) begin
      if (n == retrig_at) begin
        cpu_addr  = OAM_DMA_REG;
        cpu_wdata = 8'h07;
        cpu_wr    = 1'b1;
      end else begin
        cpu_wr = 1'b0;
      end
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1;
        break;
      end
    end
    cpu_wr = 1'b0;
    chk("done_seen", seen, 1'b1);
    chk("done_cycle", n - 1, exp_cyc);
    chk("busy_at_done", busy, 1'b0);
    chk("err_at_done", err, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
  endtask

  initial begin
    int n;
    int hung;
    bit dseen;
    rst_n = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wr = 1'b0;
    stall_en = 1'b0; hang_en = 1'b0; spur = 1'b0; hang_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd", bus.Cmd, 1'b0);
    chk("rst_rw", bus.RW, 1'b0);
    chk("rst_addr", bus.Addr, 16'h0000);
    chk("rst_wdata", bus.WData, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain page 02 copy, single-cycle responder.
    push_exp(8'h02, 256, 256);
    start(8'h02);
    wait_done(1536, -1);

    // Every 16th read stalls 3 extra cycles.
    stall_en = 1'b1;
    push_exp(8'h02, 256, 256);
    start(8'h02);
    wait_done(1536 + 48, -1);
    stall_en = 1'b0;

    // Read of byte 7 never finishes.
    hang_en = 1'b1;
    hang_addr = 16'h0207;
    push_exp(8'h02, 7, 7);
    start(8'h02);
    n = 1; hung = 0; dseen = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
      if (bus.Cmd && bus.Addr == hang_addr) hung++;
      if (done) dseen = 1;
    end
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_err", err, 1'b1);
    chk("tmo_cmd", bus.Cmd, 1'b0);
    chk("tmo_cmd_cycles", hung, 255);
    chk("tmo_no_done", dseen, 1'b0);
    chk("tmo_rd_queue", exp_rd.size(), 0);
    chk("tmo_wr_queue", exp_wr.size(), 0);
    hang_en = 1'b0;

    // Re-trigger at byte 100 with another page must be ignored; also clears err.
    push_exp(8'h02, 256, 256);
    start(8'h02);
    wait_done(1536, 601);

    // Reset during the write of byte 50, then a fresh transfer.
    push_exp(8'h02, 256, 256);
    start(8'h02);
    n = 1;
    while (n < 304) begin
      @(negedge clk);
      n++;
    end
    chk("b50_in_write", {bus.Cmd, bus.RW}, 2'b11);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cmd", bus.Cmd, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_addr", bus.Addr, 16'h0000);
    chk("mid_rst_rw", bus.RW, 1'b0);
    chk("mid_rst_wdata", bus.WData, 8'h00);
    chk("mid_rst_rd_left", exp_rd.size(), 205);
    chk("mid_rst_wr_left", exp_wr.size(), 206);
    exp_rd.delete();
    exp_wr.delete();
    rst_n = 1'b1;
    push_exp(8'h02, 256, 256);
    start(8'h02);
    wait_done(1536, -1);

    // Top page: last read at FFFF, no wrap; then spurious Finish while idle.
    push_exp(8'hFF, 256, 256);
    start(8'hFF);
    wait_done(1536, -1);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("spur_no_cmd", bus.Cmd, 1'b0);
      chk("spur_no_busy", busy, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
